// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: sweeps a,b of the all-gates stage over 00..11, captures the
// seven gate outputs per combination and checks them against the golden table.
// Ports: clk, rst_n (async low); start (sweep request, taken in IDLE only);
//   a_o/b_o (gate inputs = idx[1]/idx[0]); gate_i[6:0] {xnor,xor,nor,nand,or,and,not};
//   busy (SETTLE/SAMPLE); done (1-cycle end pulse); pass (set in DONE, 1 = no mismatch);
//   err_vec[3:0] (per-combination mismatch); table_o[27:0] (slot i at [7i+6:7i]).
// Option: GATE_CHK_STOP_ON_FAIL_EN ends the sweep at the first mismatching sample.
module gate_sweep_checker #(
  parameter int SETTLE_W      = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        a_o,
  output logic        b_o,
  input  logic [6:0]  gate_i,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  err_vec,
  output logic [27:0] table_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [SETTLE_W-1:0] LP_LOAD = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [SETTLE_W-1:0] LP_LAST = SETTLE_W'(1);

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_idx;
  logic [SETTLE_W-1:0] r_cnt;
  logic [6:0]          w_exp;
  logic                w_miss;

  always_comb begin
    w_exp = 7'h59;
    unique case (r_idx)
      2'd0: w_exp = 7'h59;
      2'd1: w_exp = 7'h2D;
      2'd2: w_exp = 7'h2C;
      2'd3: w_exp = 7'h46;
    endcase
  end

  assign w_miss = (gate_i != w_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_SETTLE;
      S_SETTLE: if (r_cnt == LP_LAST) w_next = S_SAMPLE;
      S_SAMPLE: begin
        if (r_idx == 2'd3) w_next = S_DONE;
        else               w_next = S_SETTLE;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        if (w_miss)        w_next = S_DONE;
`endif
      end
      S_DONE:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= 2'd0;
      r_cnt   <= '0;
      pass    <= 1'b0;
      err_vec <= 4'd0;
      table_o <= 28'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx   <= 2'd0;
            r_cnt   <= LP_LOAD;
            pass    <= 1'b0;
            err_vec <= 4'd0;
            table_o <= 28'd0;
          end
        end
        S_SETTLE: r_cnt <= r_cnt - LP_LAST;
        S_SAMPLE: begin
          table_o[7*int'(r_idx) +: 7] <= gate_i;
          err_vec[r_idx]              <= w_miss;
          if (w_next == S_SETTLE) begin
            r_idx <= r_idx + 2'd1;
            r_cnt <= LP_LOAD;
          end
        end
        S_DONE: begin
          // err_vec already holds the last sample here
          pass  <= (err_vec == 4'd0);
          r_idx <= 2'd0;
        end
      endcase
    end
  end

  assign a_o  = r_idx[1];
  assign b_o  = r_idx[0];
  assign busy = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: self-checking bench for gate_sweep_checker.
// Drives a fault-injectable gate model and checks each sweep against a reference.
module tb_gate_sweep_checker;

  localparam int S = 2;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        a_o;
  logic        b_o;
  logic [6:0]  gate_i;
  logic        busy;
  logic        done;
  logic        pass;
  logic [3:0]  err_vec;
  logic [27:0] table_o;

  logic [6:0]  sa0_m;
  logic [6:0]  sa1_m;
  int          n_cmp;
  int          n_bad;

  gate_sweep_checker #(
    .SETTLE_W(4),
    .SETTLE_CYCLES(S)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .a_o(a_o),
    .b_o(b_o),
    .gate_i(gate_i),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_vec(err_vec),
    .table_o(table_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] gate_ref(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b, ~a};
  endfunction

  assign gate_i = (gate_ref(a_o, b_o) & ~sa0_m) | sa1_m;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [6:0] s0, input logic [6:0] s1,
                       output logic [27:0] t, output logic [3:0] e,
                       output int de);
    logic [6:0] g;
    logic [6:0] f;
    logic [1:0] ii;
    t  = '0;
    e  = '0;
    de = 4 * (S + 1);
    for (int i = 0; i < 4; i++) begin
      ii = 2'(i);
      g  = gate_ref(ii[1], ii[0]);
      f  = (g & ~s0) | s1;
      t[7*i +: 7] = f;
      e[i] = (f != g);
      if (STOP && (f != g)) begin
        de = (i + 1) * (S + 1);
        break;
      end
    end
  endtask

  // entered #1 after the accepting edge
  task automatic finish_sweep();
    logic [27:0] et;
    logic [3:0]  ee;
    int          de;
    int          k;
    model(sa0_m, sa1_m, et, ee, de);
    k = 0;
    while (!done && k < 200) begin
      chk("busy", busy, 1);
      chk("ab_idx", {a_o, b_o}, k / (S + 1));
      @(posedge clk);
      #1;
      k++;
    end
    chk("done_edge", k, de);
    chk("busy_in_done", busy, 0);
    chk("err_vec", err_vec, ee);
    chk("table", table_o, et);
    @(posedge clk);
    #1;
    chk("pass", pass, (ee == 4'd0));
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("err_hold", err_vec, ee);
  endtask

  task automatic run_sweep(input logic [6:0] s0, input logic [6:0] s1);
    sa0_m = s0;
    sa1_m = s1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_sweep();
  endtask

  initial begin
    int          k;
    logic [6:0]  r0;
    logic [6:0]  r1;
    n_cmp = 0;
    n_bad = 0;
    sa0_m = '0;
    sa1_m = '0;
    start = 1'b0;
    rst_n = 1'b0;
    #23;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      chk("reset_idle",
          {a_o, b_o, busy, done, pass, err_vec, table_o}, 0);
      @(posedge clk);
      #1;
    end

    run_sweep(7'h00, 7'h00);
    chk("golden", table_o, 28'h8CB16D9);
    chk("golden_pass", pass, 1);

    run_sweep(7'h02, 7'h00);
    chk("and_sa0_slot3", table_o[27:21], 7'h44);

    // start held high: second accept directly after one IDLE cycle
    sa0_m = '0;
    sa1_m = '0;
    start = 1'b1;
    @(posedge clk);
    #1;
    finish_sweep();
    chk("hold_pass1", pass, 1);
    @(posedge clk);
    #1;
    chk("hold_reaccept", busy, 1);
    chk("hold_pass_clr", pass, 0);
    chk("hold_tab_clr", table_o, 0);
    sa1_m = 7'h01;
    finish_sweep();
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_release", busy, 0);

    // async reset during idx=2 SETTLE
    sa0_m = '0;
    sa1_m = '0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (!(a_o && !b_o) && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("reach_idx2", {a_o, b_o, busy}, 3'b101);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst",
        {a_o, b_o, busy, done, pass, err_vec, table_o}, 0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_sweep(7'h00, 7'h00);
    chk("post_rst_golden", table_o, 28'h8CB16D9);

    run_sweep(7'h20, 7'h00);
    if (STOP) begin
      chk("stop_err", err_vec, 4'b0010);
      chk("stop_slot1", table_o[13:7], 7'h0D);
      chk("stop_hi_zero", table_o[27:14], 0);
    end

    for (int n = 0; n < 20; n++) begin
      r0 = 7'($urandom);
      r1 = 7'($urandom);
      if ($urandom_range(0, 2) == 0) r0 = '0;
      if ($urandom_range(0, 1) == 0) r1 = '0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      run_sweep(r0, r1 & ~r0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
